mem_stage: RTL and testbench

//  RV32I MEM stage: sits between ex_mem and mem_wb. Non-memory instructions pass through unchanged.

---
 rtl/mem_stage_pkg.sv | 50 +++++
 rtl/mem_stage_load_ext.sv | 26 ++
 rtl/mem_stage.sv | 132 +++++++++++++
 tb/tb_mem_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: memory opcode encoding, FSM states, opcode decode helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_stage_pkg;

    localparam int STALL_W   = 6;   // width of the stall bus
    localparam int STALL_MEM = 4;   // stall bus bit: mem stage held (bit 5 is wb held)
    localparam int MEMOP_W   = 4;   // width of the memory opcode bus

    // Memory opcodes carried from ex_mem; codes not listed here behave as NOP.
    typedef enum logic [MEMOP_W-1:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LH  = 4'd2,
        MEM_LW  = 4'd3,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    function automatic logic op_is_load(input logic [MEMOP_W-1:0] op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic op_is_store(input logic [MEMOP_W-1:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    // Transfer size in bytes; 0 for anything that is not an access.
    function automatic logic [2:0] op_len(input logic [MEMOP_W-1:0] op);
        logic [2:0] len;
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: len = 3'd1;
            MEM_LH, MEM_LHU, MEM_SH: len = 3'd2;
            MEM_LW, MEM_SW:          len = 3'd4;
            default:                 len = 3'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load data extension: sign- or zero-extends the LSB-aligned bytes returned by mem_ctrl.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module mem_load_ext
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [MEMOP_W-1:0] i_mem_op,
    input  logic [XLEN-1:0]    i_rdata,
    output logic [XLEN-1:0]    o_data
);

    // Byte/half loads only look at the low bytes; anything above is don't-care from mem_ctrl.
    always_comb begin
        o_data = i_rdata;
        case (i_mem_op)
            MEM_LB:  o_data = {{(XLEN-8){i_rdata[7]}},   i_rdata[7:0]};
            MEM_LH:  o_data = {{(XLEN-16){i_rdata[15]}}, i_rdata[15:0]};
            MEM_LBU: o_data = {{(XLEN-8){1'b0}},         i_rdata[7:0]};
            MEM_LHU: o_data = {{(XLEN-16){1'b0}},        i_rdata[15:0]};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: passes non-memory ops straight through, runs a req/done access with mem_ctrl for loads/stores.
// Latency: 0 cycles for non-memory ops; memory ops take 1 issue cycle + mem_ctrl latency, result held until wb takes it.
// Backpressure: raises stall_req_out while an access is pending; holds the result while stall_in[4] is set; rdy_in=0 freezes all state.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic [STALL_W-1:0]   stall_in,
    output logic                 stall_req_out,

    input  logic [4:0]           rd_address_in,
    input  logic [XLEN-1:0]      rd_data_in,
    input  logic [MEMOP_W-1:0]   mem_op_in,
    input  logic [XLEN-1:0]      mem_addr_in,
    input  logic [XLEN-1:0]      mem_wdata_in,
    input  logic [CSR_AW-1:0]    csr_in,
    input  logic                 csr_write_enable_in,
    input  logic [XLEN-1:0]      csr_write_data_in,

    output logic                 mem_req_out,
    output logic                 mem_we_out,
    output logic [2:0]           mem_len_out,
    output logic [XLEN-1:0]      mem_addr_out,
    output logic [XLEN-1:0]      mem_wdata_out,
    input  logic                 mem_done_in,
    input  logic [XLEN-1:0]      mem_rdata_in,

    output logic [4:0]           rd_address,
    output logic [XLEN-1:0]      rd_data,
    output logic [CSR_AW-1:0]    csr_out,
    output logic                 csr_write_enable_out,
    output logic [XLEN-1:0]      csr_write_data_out
);

    mem_state_e      r_state;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [2:0]      r_mem_len;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;
    logic [XLEN-1:0] r_result;

    logic            w_is_load;
    logic            w_is_store;
    logic            w_is_mem;
    logic [XLEN-1:0] w_load_ext;
    logic            w_unused_stall;

    assign w_is_load  = op_is_load(mem_op_in);
    assign w_is_store = op_is_store(mem_op_in);
    assign w_is_mem   = w_is_load | w_is_store;

    // Only the mem-stage hold bit matters here; the other stall bits belong to other stages.
    assign w_unused_stall = ^{stall_in[STALL_W-1:STALL_MEM+1], stall_in[STALL_MEM-1:0]};

    mem_load_ext #(
        .XLEN (XLEN)
    ) u_load_ext (
        .i_mem_op (mem_op_in),
        .i_rdata  (mem_rdata_in),
        .o_data   (w_load_ext)
    );

    // Access FSM: issue the request, wait for done, hold the result until mem_wb has taken it.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_len   <= 3'd0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_result    <= '0;
        end else if (rdy_in) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_mem) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_is_store;
                        r_mem_len   <= op_len(mem_op_in);
                        r_mem_addr  <= mem_addr_in;   // misaligned addresses go out as-is
                        r_mem_wdata <= mem_wdata_in;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_done_in) begin
                        r_result  <= w_load_ext;
                        r_mem_req <= 1'b0;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Stage is held while wb is stalled; leave only once the result has moved on.
                    if (!stall_in[STALL_MEM]) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Stall while an access is being issued or is outstanding; DONE already has its result.
    always_comb begin
        stall_req_out = ((r_state == ST_IDLE) && w_is_mem) || (r_state == ST_WAIT);
    end

    // Writeback-side outputs: pass-through, with load results substituted once captured.
    always_comb begin
        rd_address           = w_is_store ? 5'd0 : rd_address_in;
        rd_data              = ((r_state == ST_DONE) && w_is_load) ? r_result : rd_data_in;
        csr_out              = csr_in;
        csr_write_enable_out = csr_write_enable_in;
        csr_write_data_out   = csr_write_data_in;
    end

    assign mem_req_out   = r_mem_req;
    assign mem_we_out    = r_mem_we;
    assign mem_len_out   = r_mem_len;
    assign mem_addr_out  = r_mem_addr;
    assign mem_wdata_out = r_mem_wdata;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: each instruction is expanded into a per-cycle schedule of expected outputs.
// Latency: n/a.
// Backpressure: the bench plays mem_ctrl and the stall controller from that schedule.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic [5:0]  stall_in;
    logic        stall_req_out;
    logic [4:0]  rd_address_in;
    logic [31:0] rd_data_in;
    logic [3:0]  mem_op_in;
    logic [31:0] mem_addr_in, mem_wdata_in;
    logic [11:0] csr_in;
    logic        csr_write_enable_in;
    logic [31:0] csr_write_data_in;
    logic        mem_req_out, mem_we_out;
    logic [2:0]  mem_len_out;
    logic [31:0] mem_addr_out, mem_wdata_out;
    logic        mem_done_in;
    logic [31:0] mem_rdata_in;
    logic [4:0]  rd_address;
    logic [31:0] rd_data;
    logic [11:0] csr_out;
    logic        csr_write_enable_out;
    logic [31:0] csr_write_data_out;

    mem_stage #(.XLEN(32), .CSR_AW(12)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .stall_in(stall_in),
        .stall_req_out(stall_req_out),
        .rd_address_in(rd_address_in), .rd_data_in(rd_data_in), .mem_op_in(mem_op_in),
        .mem_addr_in(mem_addr_in), .mem_wdata_in(mem_wdata_in),
        .csr_in(csr_in), .csr_write_enable_in(csr_write_enable_in), .csr_write_data_in(csr_write_data_in),
        .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .mem_len_out(mem_len_out),
        .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
        .mem_done_in(mem_done_in), .mem_rdata_in(mem_rdata_in),
        .rd_address(rd_address), .rd_data(rd_data), .csr_out(csr_out),
        .csr_write_enable_out(csr_write_enable_out), .csr_write_data_out(csr_write_data_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Expected outputs for the current cycle window.
    bit          exp_vld = 1'b0;
    logic        exp_stall, exp_req, exp_we;
    logic [2:0]  exp_len;
    logic [31:0] exp_addr, exp_wdata, exp_rd_data, exp_csr_wd;
    logic [4:0]  exp_rda;
    logic [11:0] exp_csr;
    logic        exp_csr_we;

    // Observations captured by the runner for the hand-computed checks.
    int          cap_stall_cnt;
    logic        cap_we, cap_req_last;
    logic [2:0]  cap_len;
    logic [31:0] cap_addr, cap_wdata, cap_done_first, cap_done_last;
    logic [4:0]  cap_rda;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference load extension, computed arithmetically.
    function automatic logic [31:0] model_ext(input logic [3:0] op, input logic [31:0] d);
        int v;
        case (op)
            MEM_LB:  begin v = int'(d & 32'hFF);   if (v >= 128)   v = v - 256;   end
            MEM_LH:  begin v = int'(d & 32'hFFFF); if (v >= 32768) v = v - 65536; end
            MEM_LBU: v = int'(d & 32'hFF);
            MEM_LHU: v = int'(d & 32'hFFFF);
            default: v = int'(d);
        endcase
        return 32'(v);
    endfunction

    function automatic logic [2:0] model_len(input logic [3:0] op);
        if (op inside {MEM_LB, MEM_LBU, MEM_SB}) return 3'd1;
        if (op inside {MEM_LH, MEM_LHU, MEM_SH}) return 3'd2;
        return 3'd4;
    endfunction

    // Per-cycle comparison against the schedule.
    always @(negedge clk_in) begin
        if (exp_vld) begin
            chk("stall_req", 32'(stall_req_out), 32'(exp_stall));
            chk("mem_req", 32'(mem_req_out), 32'(exp_req));
            if (exp_req) begin
                chk("mem_we", 32'(mem_we_out), 32'(exp_we));
                chk("mem_len", 32'(mem_len_out), 32'(exp_len));
                chk("mem_addr", mem_addr_out, exp_addr);
                chk("mem_wdata", mem_wdata_out, exp_wdata);
            end
            chk("rd_address", 32'(rd_address), 32'(exp_rda));
            chk("rd_data", rd_data, exp_rd_data);
            chk("csr_out", 32'(csr_out), 32'(exp_csr));
            chk("csr_we", 32'(csr_write_enable_out), 32'(exp_csr_we));
            chk("csr_wd", csr_write_data_out, exp_csr_wd);
        end
    end

    // One instruction: window 0 issues, windows 1..lat wait (done on window lat),
    // windows lat+1..lat+hold are held by wb, window lat+hold+1 releases.
    task automatic run_instr(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdi, input logic [31:0] rdata,
                             input int lat, input int hold,
                             input int freeze_at, input int freeze_len, input int freeze_pct);
        bit          is_ld, is_st, is_mem;
        logic [31:0] res;
        int          last;
        int          nfz;
        is_ld  = op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
        is_st  = op inside {MEM_SB, MEM_SH, MEM_SW};
        is_mem = is_ld || is_st;
        res    = model_ext(op, rdata);

        mem_op_in           = op;
        mem_addr_in         = addr;
        mem_wdata_in        = wdata;
        rd_data_in          = rdi;
        rd_address_in       = 5'($urandom);
        csr_in              = 12'($urandom);
        csr_write_enable_in = 1'($urandom);
        csr_write_data_in   = $urandom;

        exp_rda    = is_st ? 5'd0 : rd_address_in;
        exp_we     = is_st;
        exp_len    = model_len(op);
        exp_addr   = addr;
        exp_wdata  = wdata;
        exp_csr    = csr_in;
        exp_csr_we = csr_write_enable_in;
        exp_csr_wd = csr_write_data_in;
        exp_vld    = 1'b1;

        cap_stall_cnt = 0;
        last = is_mem ? (lat + hold + 1) : 0;
        for (int k = 0; k <= last; k++) begin
            exp_stall   = is_mem && (k <= lat);
            exp_req     = is_mem && (k >= 1) && (k <= lat);
            exp_rd_data = (is_ld && (k > lat)) ? res : rdi;

            nfz = (k == freeze_at) ? freeze_len
                                   : (($urandom_range(99) < freeze_pct) ? int'($urandom_range(1, 2)) : 0);
            for (int f = 0; f < nfz; f++) begin
                rdy_in       = 1'b0;
                mem_done_in  = 1'($urandom);
                mem_rdata_in = $urandom;
                stall_in     = 6'($urandom);
                @(posedge clk_in);
                #1;
            end

            rdy_in       = 1'b1;
            mem_rdata_in = $urandom;
            if (is_mem && (k <= lat)) begin
                stall_in    = {2'b01, 4'($urandom)};
                mem_done_in = (k == lat);
                if (k == lat) mem_rdata_in = rdata;
            end else if (is_mem && (k <= lat + hold)) begin
                stall_in    = {2'b11, 4'($urandom)};
                mem_done_in = 1'($urandom);
            end else if (is_mem) begin
                stall_in    = {2'b00, 4'($urandom)};
                mem_done_in = 1'($urandom);
            end else begin
                stall_in    = 6'($urandom);
                mem_done_in = 1'($urandom);
            end

            @(negedge clk_in);
            if (stall_req_out) cap_stall_cnt++;
            if (k == 1) begin
                cap_we    = mem_we_out;
                cap_len   = mem_len_out;
                cap_addr  = mem_addr_out;
                cap_wdata = mem_wdata_out;
                cap_rda   = rd_address;
            end
            if (is_mem && (k == lat + 1)) cap_done_first = rd_data;
            if (k == last) begin
                cap_done_last = rd_data;
                cap_req_last  = mem_req_out;
            end
            @(posedge clk_in);
            #1;
        end
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; stall_in = 6'd0; mem_op_in = MEM_NOP;
        rd_address_in = 5'd0; rd_data_in = 32'd0; mem_addr_in = 32'd0; mem_wdata_in = 32'd0;
        csr_in = 12'd0; csr_write_enable_in = 1'b0; csr_write_data_in = 32'd0;
        mem_done_in = 1'b0; mem_rdata_in = 32'd0;

        // Reset state
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_req", 32'(mem_req_out), 32'd0);
        chk("rst_we", 32'(mem_we_out), 32'd0);
        chk("rst_len", 32'(mem_len_out), 32'd0);
        chk("rst_addr", mem_addr_out, 32'd0);
        chk("rst_wdata", mem_wdata_out, 32'd0);
        chk("rst_stall", 32'(stall_req_out), 32'd0);
        rst_in = 1'b1;

        // LW with 4-cycle access
        run_instr(MEM_LW, 32'h1000, $urandom, $urandom, 32'h800000F0, 4, 0, -1, 0, 0);
        chk("t1_stall_cycles", 32'(cap_stall_cnt), 32'd5);
        chk("t1_len", 32'(cap_len), 32'd4);
        chk("t1_addr", cap_addr, 32'h1000);
        chk("t1_rd_data", cap_done_first, 32'h800000F0);

        // Extension cases, with garbage in the unused upper bytes
        run_instr(MEM_LB, $urandom, $urandom, $urandom, 32'h123456F0, 2, 0, -1, 0, 0);
        chk("t2_lb", cap_done_first, 32'hFFFFFFF0);
        run_instr(MEM_LBU, $urandom, $urandom, $urandom, 32'h123456F0, 1, 0, -1, 0, 0);
        chk("t2_lbu", cap_done_first, 32'h000000F0);
        run_instr(MEM_LH, $urandom, $urandom, $urandom, 32'hABCD8001, 3, 0, -1, 0, 0);
        chk("t2_lh", cap_done_first, 32'hFFFF8001);
        run_instr(MEM_LHU, $urandom, $urandom, $urandom, 32'hABCD8001, 2, 0, -1, 0, 0);
        chk("t2_lhu", cap_done_first, 32'h00008001);

        // Halfword store
        run_instr(MEM_SH, 32'h20, 32'h12345678, 32'h0BADF00D, $urandom, 2, 0, -1, 0, 0);
        chk("t3_we", 32'(cap_we), 32'd1);
        chk("t3_len", 32'(cap_len), 32'd2);
        chk("t3_addr", cap_addr, 32'h20);
        chk("t3_wdata", cap_wdata, 32'h12345678);
        chk("t3_rd_address", 32'(cap_rda), 32'd0);
        chk("t3_rd_data", cap_done_last, 32'h0BADF00D);

        // Result held while wb is stalled for 3 cycles
        run_instr(MEM_LW, $urandom, $urandom, $urandom, 32'hDEADBEEF, 2, 3, -1, 0, 0);
        chk("t4_held_data", cap_done_last, 32'hDEADBEEF);
        chk("t4_req_low", 32'(cap_req_last), 32'd0);

        // Plain ALU result
        run_instr(MEM_NOP, $urandom, $urandom, 32'h55, $urandom, 1, 0, -1, 0, 0);
        chk("t5_rd_data", cap_done_last, 32'h55);
        chk("t5_stall", 32'(cap_stall_cnt), 32'd0);

        // Global freeze for 2 cycles in the middle of WAIT
        run_instr(MEM_LW, $urandom, $urandom, $urandom, 32'hCAFEF00D, 3, 0, 2, 2, 0);
        chk("t6_stall_cycles", 32'(cap_stall_cnt), 32'd4);
        chk("t6_rd_data", cap_done_first, 32'hCAFEF00D);

        // Reset asserted during WAIT
        exp_vld = 1'b0;
        mem_op_in = MEM_SW; mem_addr_in = 32'h44; mem_wdata_in = 32'h99;
        rdy_in = 1'b1; stall_in = 6'b010000; mem_done_in = 1'b0;
        @(posedge clk_in);
        #1;
        chk("t6_req_before_rst", 32'(mem_req_out), 32'd1);
        #2;
        rst_in = 1'b0;
        #1;
        chk("t6_req_async_drop", 32'(mem_req_out), 32'd0);
        chk("t6_addr_async_clr", mem_addr_out, 32'd0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        mem_op_in = MEM_NOP;
        @(negedge clk_in);
        chk("t6_idle_after_rst", 32'(stall_req_out), 32'd0);
        @(posedge clk_in);
        #1;

        // Randomized mix, including undefined opcodes that act as NOP
        for (int n = 0; n < 120; n++) begin
            run_instr(4'($urandom_range(15)), $urandom, $urandom, $urandom, $urandom,
                      int'($urandom_range(1, 5)), int'($urandom_range(0, 3)), -1, 0, 15);
        end

        exp_vld = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
